// File: rtl/chan_scan_pkg.sv
// Shared types for the channel scan multiplexer: FSM state encoding and mode values.
// Latency: n/a; backpressure: n/a.
package chan_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } cs_state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_dwell_counter.sv
// Round-robin scan position with per-channel dwell count and wrap pulse request.
// Latency: position is combinational from state, steps on advance_en; backpressure: none, advance_en=0 freezes.
module scan_dwell_counter #(
  parameter  int N_CH  = 4,
  parameter  int DWELL = 8,
  localparam int SELW  = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance_en,
  input  logic            restart,
  output logic [SELW-1:0] scan_ch,
  output logic            wrap
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [SELW-1:0] ch_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_cur;
  logic            pend_q;
  logic            expire;
  logic            last_ch;

  // restart overrides the saved position so the restart cycle itself shows channel 0
  always_comb begin
    scan_ch = restart ? '0 : ch_q;
    cnt_cur = restart ? '0 : cnt_q;
    expire  = (cnt_cur == CW'(DWELL - 1));
    last_ch = (scan_ch == SELW'(N_CH - 1));
    wrap    = advance_en & ~restart & pend_q;
  end

  // pend_q marks that the position just wrapped; it is reported when channel 0 is first shown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q   <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else if (advance_en) begin
      if (expire) begin
        cnt_q  <= '0;
        ch_q   <= last_ch ? '0 : scan_ch + 1'b1;
        pend_q <= last_ch;
      end else begin
        cnt_q  <= cnt_cur + 1'b1;
        ch_q   <= scan_ch;
        pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/chan_scan_mux.sv
// Registered N-channel mux with manual select and round-robin auto-scan; tags output with its channel.
// Latency: 1 cycle; backpressure: none, en=0 holds outputs with out_valid=0.
module chan_scan_mux #(
  parameter  int WIDTH = 4,
  parameter  int N_CH  = 4,
  parameter  int DWELL = 8,
  localparam int SELW  = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel,
  input  logic [N_CH*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_ch,
  output logic                  out_valid,
  output logic                  ch_wrap
);

  import chan_scan_pkg::*;

  cs_state_t       state;
  cs_state_t       next_state;
  logic            last_mode;
  logic            advance_en;
  logic            restart;
  logic            sel_ok;
  logic [SELW-1:0] scan_ch;
  logic            scan_wrap;
  logic [WIDTH-1:0] man_dat;
  logic [WIDTH-1:0] scan_dat;

  scan_dwell_counter #(
    .N_CH (N_CH),
    .DWELL(DWELL)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance_en(advance_en),
    .restart   (restart),
    .scan_ch   (scan_ch),
    .wrap      (scan_wrap)
  );

  // Scan restarts from channel 0 unless we are resuming a paused scan
  always_comb begin
    next_state = IDLE;
    if (en) next_state = (mode == MODE_SCAN) ? SCAN : MANUAL;
    advance_en = (next_state == SCAN);
    restart    = advance_en &&
                 ((state == MANUAL) || (state == IDLE && last_mode == MODE_MANUAL));
    sel_ok     = (int'(sel) < N_CH);
  end

  always_comb begin
    man_dat  = '0;
    scan_dat = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (int'(sel) == k)     man_dat  = data_in[k*WIDTH +: WIDTH];
      if (int'(scan_ch) == k) scan_dat = data_in[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_mode <= MODE_MANUAL;
    end else begin
      state <= next_state;
      if (en) last_mode <= mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      ch_wrap   <= 1'b0;
    end else begin
      case (next_state)
        MANUAL: begin
          ch_wrap <= 1'b0;
          if (sel_ok) begin
            out_data  <= man_dat;
            out_ch    <= sel;
            out_valid <= 1'b1;
          end else begin
            out_valid <= 1'b0;
          end
        end
        SCAN: begin
          out_data  <= scan_dat;
          out_ch    <= scan_ch;
          out_valid <= 1'b1;
          ch_wrap   <= scan_wrap;
        end
        default: begin
          out_valid <= 1'b0;
          ch_wrap   <= 1'b0;
        end
      endcase
    end
  end

endmodule
